// File: rtl/compressed_aligner.sv
// Splits a stream of 32-bit fetch words into 16/32-bit instructions, carrying a
// residual halfword across word boundaries and holding a word for a second compressed emission.
module compressed_aligner #(
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_word,
   input  logic [PC_W-1:0] pc_in,
   input  logic            flush,
   input  logic [PC_W-1:0] flush_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     instr_out,
   output logic            instr_is_c,
   output logic [PC_W-1:0] pc_out,
   output logic            f1f1,
   output logic            f1f2,
   output logic            hf,
   output logic            fh,
   output logic            hh,
   output logic            stall_compressed
);

   typedef enum logic [1:0] {EMPTY, HPEND, RESID} state_t;

   localparam logic [4:0] CLS_F1F1 = 5'b10000;
   localparam logic [4:0] CLS_F1F2 = 5'b01000;
   localparam logic [4:0] CLS_HF   = 5'b00100;
   localparam logic [4:0] CLS_FH   = 5'b00010;
   localparam logic [4:0] CLS_HH   = 5'b00001;

   state_t          state_reg;
   logic            skip_lo_reg;
   logic            hpend_fh_reg;
   logic [15:0]     s_reg;
   logic [PC_W-1:0] sp_reg;

   logic [15:0]     lo, hi;
   logic            lo_c, hi_c;
   logic [PC_W-1:0] pc_hi;
   logic [4:0]      cls;
   logic            fire, consume;

   assign lo      = in_word[15:0];
   assign hi      = in_word[31:16];
   assign lo_c    = (lo[1:0] != 2'b11);
   assign hi_c    = (hi[1:0] != 2'b11);
   assign pc_hi   = pc_in + PC_W'(2);
   assign fire    = out_valid & out_ready;
   assign consume = in_valid & in_ready;
   assign {f1f1, f1f2, hf, fh, hh} = cls;

   always_comb begin
      in_ready         = 1'b0;
      out_valid        = 1'b0;
      instr_out        = 32'h0;
      instr_is_c       = 1'b0;
      pc_out           = '0;
      cls              = 5'b0;
      stall_compressed = 1'b0;
      if (!reset && !flush) begin
         unique case (state_reg)
            EMPTY: begin
               if (skip_lo_reg) begin
                  // A full hi after a mid-word redirect is absorbed silently.
                  if (hi_c) begin
                     in_ready   = out_ready;
                     out_valid  = in_valid;
                     instr_out  = {16'h0, hi};
                     instr_is_c = 1'b1;
                     pc_out     = pc_hi;
                     cls        = CLS_FH;
                  end else begin
                     in_ready = 1'b1;
                  end
               end else if (!lo_c) begin
                  in_ready  = out_ready;
                  out_valid = in_valid;
                  instr_out = in_word;
                  pc_out    = pc_in;
                  cls       = CLS_F1F1;
               end else begin
                  out_valid  = in_valid;
                  instr_out  = {16'h0, lo};
                  instr_is_c = 1'b1;
                  pc_out     = pc_in;
                  if (hi_c) begin
                     cls              = CLS_HH;
                     stall_compressed = 1'b1;
                  end else begin
                     in_ready = out_ready;
                     cls      = CLS_HF;
                  end
               end
            end
            HPEND: begin
               in_ready   = out_ready;
               out_valid  = 1'b1;
               instr_out  = {16'h0, hi};
               instr_is_c = 1'b1;
               pc_out     = pc_hi;
               cls        = hpend_fh_reg ? CLS_FH : CLS_HH;
            end
            RESID: begin
               out_valid = in_valid;
               instr_out = {lo, s_reg};
               pc_out    = sp_reg;
               cls       = CLS_F1F2;
               if (hi_c) stall_compressed = 1'b1;
               else      in_ready = out_ready;
            end
            default: ;
         endcase
      end
      if (!out_valid) begin
         instr_out        = 32'h0;
         instr_is_c       = 1'b0;
         pc_out           = '0;
         cls              = 5'b0;
         stall_compressed = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= EMPTY;
         skip_lo_reg  <= 1'b0;
         hpend_fh_reg <= 1'b0;
         s_reg        <= 16'h0;
         sp_reg       <= '0;
      end else if (flush) begin
         state_reg    <= EMPTY;
         skip_lo_reg  <= flush_pc[1];
         hpend_fh_reg <= 1'b0;
         s_reg        <= 16'h0;
         sp_reg       <= flush_pc;
      end else begin
         if (consume) skip_lo_reg <= 1'b0;
         unique case (state_reg)
            EMPTY: begin
               if (skip_lo_reg) begin
                  if (consume && !hi_c) begin
                     s_reg     <= hi;
                     sp_reg    <= pc_hi;
                     state_reg <= RESID;
                  end
               end else if (fire && lo_c) begin
                  if (hi_c) begin
                     state_reg    <= HPEND;
                     hpend_fh_reg <= 1'b0;
                  end else begin
                     s_reg     <= hi;
                     sp_reg    <= pc_hi;
                     state_reg <= RESID;
                  end
               end
            end
            HPEND: if (fire) state_reg <= EMPTY;
            RESID: begin
               if (fire) begin
                  if (hi_c) begin
                     state_reg    <= HPEND;
                     hpend_fh_reg <= 1'b1;
                  end else begin
                     s_reg  <= hi;
                     sp_reg <= pc_hi;
                  end
               end
            end
            default: state_reg <= EMPTY;
         endcase
      end
   end

endmodule

// File: doc/compressed_aligner.md
COMPRESSED_ALIGNER -- requirements
Module: compressed_aligner

Interface
REQ-001 SHALL have parameter PC_W, default 32, width of pc_in/pc_out.
REQ-002 SHALL have clk, input, 1, sole clock, all state on rising edge.
REQ-003 SHALL have reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have in_valid/in_ready (in/out, 1 each), fetch-word handshake.
REQ-005 SHALL have in_word, input, 32, fetched word: lo=[15:0], hi=[31:16].
REQ-006 SHALL have pc_in, input, PC_W, byte address of in_word, bits[1:0]=00.
REQ-007 SHALL have flush, input, 1, redirect; flush_pc, input, PC_W, redirect target.
REQ-008 SHALL have out_valid/out_ready (out/in, 1 each), instruction handshake.
REQ-009 SHALL have instr_out (out, 32), instr_is_c (out, 1; compressed in [15:0], [31:16]=0), pc_out (out, PC_W).
REQ-010 SHALL have f1f1, f1f2, hf, fh, hh, output, 1 each, one-hot class of emitted instruction, all 0 when out_valid=0.
REQ-011 SHALL have stall_compressed, output, 1, current word held for a second emission.

Function
REQ-012 Halfword h is compressed iff h[1:0]!=2'b11.
REQ-013 State: EMPTY, HPEND (hi of current word pending), RESID (saved halfword S and its pc SP); flag skip_lo.
REQ-014 Emission/advance only on out_valid&out_ready; word consumed only on in_valid&in_ready; outputs stable while out_ready=0.
REQ-015 EMPTY, lo full: emit in_word, f1f1, pc_out=pc_in, consume, stay EMPTY.
REQ-016 EMPTY, lo and hi compressed: emit lo, hh, stall_compressed=1, in_ready=0, go HPEND.
REQ-017 HPEND: emit hi, hh, pc_out=pc_in+2, stall_compressed=0, consume, go EMPTY.
REQ-018 EMPTY, lo compressed, hi full: emit lo, hf, pc_out=pc_in, consume, S=hi, SP=pc_in+2, go RESID.
REQ-019 RESID: emit {lo,S}, f1f2, pc_out=SP; hi full -> consume, S=hi, SP=pc_in+2, stay RESID; hi compressed -> stall_compressed=1, no consume, go HPEND with class fh on the hi emission.
REQ-020 skip_lo=1 (first word after flush_pc[1]=1): lo ignored; hi compressed -> emit hi, fh, pc_out=pc_in+2, consume; hi full -> no emission, out_valid=0, in_ready=1, consume, S=hi, go RESID; skip_lo cleared on consume.
REQ-021 out_valid=0 whenever a word is needed but in_valid=0 (EMPTY/RESID); HPEND needs no new word but requires in_word held stable.
REQ-022 in_ready=out_ready in consuming cases, 0 in stall cases, 0 during flush.
REQ-023 flush synchronous, highest priority: state->EMPTY, S/SP discarded, skip_lo=flush_pc[1]; that cycle out_valid=0, in_ready=0, no consume.
REQ-024 pc arithmetic modulo 2^PC_W; pc_in+2 at max wraps to 0.
REQ-025 Single cycle latency-free: outputs combinational from state and in_word; no bubbles when both sides ready except the REQ-020 full-hi case.

Reset
REQ-026 reset asserted: state EMPTY, skip_lo=0, S=0, SP=0; all outputs 0 including in_ready, independent of clk.
REQ-027 reset mid-operation discards pending halfword and HPEND; first post-reset word is treated as aligned.

Verification
REQ-028 Word 0x00000013 at pc 0x100, ready -> one emission, f1f1, pc_out 0x100, consumed same cycle.
REQ-029 Word 0x45014501 at 0x200 -> cycle1 instr 0x4501, hh, stall=1, in_ready=0; cycle2 0x4501, pc 0x202, stall=0, consumed.
REQ-030 Words 0x00134501 @0x300, 0x45010000 @0x304 -> 0x4501 hf @0x300; 0x00000013 f1f2 @0x302 stall=1; 0x4501 fh @0x306.
REQ-031 flush with flush_pc=0x402, word 0x4501FFFF @0x400 -> single emission 0x4501, fh, pc 0x402.
REQ-032 out_ready=0 for 3 cycles during HPEND -> outputs and state frozen, no word consumed; flush on cycle 2 -> EMPTY, out_valid=0 next cycle.
REQ-033 reset asserted between hf and f1f2 of REQ-030 -> all outputs 0 immediately; next word 0x00000013 emits f1f1.
